// File: rtl/fetch_pred_reg.sv
// Y86 F-stage predicted-PC register with always-taken next-PC prediction and
// saturating perf counters; prediction registers 1 cycle after fetch, held on F_stall_i.
module fetch_pred_reg #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             F_stall_i,
  input  logic [3:0]       f_icode_i,
  input  logic [63:0]      f_valC_i,
  input  logic [63:0]      f_valP_i,
  input  logic [3:0]       M_icode_i,
  input  logic             M_Cnd_i,
  input  logic [3:0]       W_icode_i,
  input  logic             W_stall_i,
  input  logic             cnt_clr_i,
  output logic [63:0]      F_predPC_o,
  output logic [63:0]      f_predPC_o,
  output logic [CNT_W-1:0] cnt_jxx_o,
  output logic [CNT_W-1:0] cnt_mispred_o,
  output logic [CNT_W-1:0] cnt_ret_o
);

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  logic [63:0]      pred_pc_d, pred_pc_q;
  logic [CNT_W-1:0] cnt_jxx_d, cnt_jxx_q;
  logic [CNT_W-1:0] cnt_mispred_d, cnt_mispred_q;
  logic [CNT_W-1:0] cnt_ret_d, cnt_ret_q;
  logic             jxx_evt, mispred_evt, ret_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    f_predPC_o = f_valP_i;
    if (f_icode_i == I_JXX || f_icode_i == I_CALL) begin
      f_predPC_o = f_valC_i;
    end
    pred_pc_d = F_stall_i ? pred_pc_q : f_predPC_o;
  end

  // A stalled JXX is counted only on the cycle it leaves fetch.
  always_comb begin
    jxx_evt     = (f_icode_i == I_JXX) && !F_stall_i;
    mispred_evt = (M_icode_i == I_JXX) && !M_Cnd_i;
    ret_evt     = (W_icode_i == I_RET) && !W_stall_i;

    cnt_jxx_d     = cnt_jxx_q;
    cnt_mispred_d = cnt_mispred_q;
    cnt_ret_d     = cnt_ret_q;
    if (cnt_clr_i) begin
      cnt_jxx_d     = '0;
      cnt_mispred_d = '0;
      cnt_ret_d     = '0;
    end else begin
      if (jxx_evt)     cnt_jxx_d     = sat_inc(cnt_jxx_q);
      if (mispred_evt) cnt_mispred_d = sat_inc(cnt_mispred_q);
      if (ret_evt)     cnt_ret_d     = sat_inc(cnt_ret_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_pc_q     <= RESET_PC;
      cnt_jxx_q     <= '0;
      cnt_mispred_q <= '0;
      cnt_ret_q     <= '0;
    end else begin
      pred_pc_q     <= pred_pc_d;
      cnt_jxx_q     <= cnt_jxx_d;
      cnt_mispred_q <= cnt_mispred_d;
      cnt_ret_q     <= cnt_ret_d;
    end
  end

  assign F_predPC_o    = pred_pc_q;
  assign cnt_jxx_o     = cnt_jxx_q;
  assign cnt_mispred_o = cnt_mispred_q;
  assign cnt_ret_o     = cnt_ret_q;

endmodule

// File: tb/tb_fetch_pred_reg.sv
// Bench for fetch_pred_reg: table vectors, directed corner sequences and a random run
// against a reference model, on an 8-bit-counter and a 32-bit-counter instance.
module tb_fetch_pred_reg;

  localparam logic [3:0] NOP = 4'h1, OPQ = 4'h6, JXX = 4'h7, CALL = 4'h8, RET = 4'h9;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall;
  logic [3:0]  f_icode;
  logic [63:0] f_valC, f_valP;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [3:0]  W_icode;
  logic        W_stall;
  logic        cnt_clr;

  logic [63:0] pc8, fpc8, pc32, fpc32;
  logic [7:0]  jxx8, mis8, ret8;
  logic [31:0] jxx32, mis32, ret32;

  always #5 clk = ~clk;

  fetch_pred_reg #(.CNT_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .F_stall_i(F_stall), .f_icode_i(f_icode),
    .f_valC_i(f_valC), .f_valP_i(f_valP), .M_icode_i(M_icode), .M_Cnd_i(M_Cnd),
    .W_icode_i(W_icode), .W_stall_i(W_stall), .cnt_clr_i(cnt_clr),
    .F_predPC_o(pc8), .f_predPC_o(fpc8), .cnt_jxx_o(jxx8),
    .cnt_mispred_o(mis8), .cnt_ret_o(ret8));

  fetch_pred_reg dut32 (
    .clk_i(clk), .rst_i(rst), .F_stall_i(F_stall), .f_icode_i(f_icode),
    .f_valC_i(f_valC), .f_valP_i(f_valP), .M_icode_i(M_icode), .M_Cnd_i(M_Cnd),
    .W_icode_i(W_icode), .W_stall_i(W_stall), .cnt_clr_i(cnt_clr),
    .F_predPC_o(pc32), .f_predPC_o(fpc32), .cnt_jxx_o(jxx32),
    .cnt_mispred_o(mis32), .cnt_ret_o(ret32));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: unbounded event counts, clipped to the counter width when compared.
  logic [63:0] m_pc;
  longint      m_jxx, m_mis, m_ret;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [63:0] clip(input longint c, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  function automatic logic [63:0] predict(input logic [3:0] ic, input logic [63:0] c,
                                          input logic [63:0] p);
    return (ic == JXX || ic == CALL) ? c : p;
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_jxx = 0; m_mis = 0; m_ret = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc8"},   pc8,   m_pc);
    chk({tag, ".pc32"},  pc32,  m_pc);
    chk({tag, ".jxx8"},  {56'h0, jxx8},  clip(m_jxx, 8));
    chk({tag, ".mis8"},  {56'h0, mis8},  clip(m_mis, 8));
    chk({tag, ".ret8"},  {56'h0, ret8},  clip(m_ret, 8));
    chk({tag, ".jxx32"}, {32'h0, jxx32}, clip(m_jxx, 32));
    chk({tag, ".mis32"}, {32'h0, mis32}, clip(m_mis, 32));
    chk({tag, ".ret32"}, {32'h0, ret32}, clip(m_ret, 32));
  endtask

  // Inputs are already driven (just after an edge); check comb output, clock once, check state.
  task automatic tick(input string tag, input bit full);
    logic [63:0] pr;
    #1;
    pr = predict(f_icode, f_valC, f_valP);
    if (full) chk({tag, ".fpred"}, fpc8, pr);
    if (cnt_clr) begin
      m_jxx = 0; m_mis = 0; m_ret = 0;
    end else begin
      if (f_icode == JXX && !F_stall) m_jxx++;
      if (M_icode == JXX && !M_Cnd)   m_mis++;
      if (W_icode == RET && !W_stall) m_ret++;
    end
    if (!F_stall) m_pc = pr;
    @(posedge clk);
    #1;
    if (full) check_all(tag);
  endtask

  task automatic idle_inputs();
    F_stall = 0; f_icode = NOP; f_valC = 0; f_valP = 0;
    M_icode = NOP; M_Cnd = 0; W_icode = NOP; W_stall = 0; cnt_clr = 0;
  endtask

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[6];
  logic [63:0] held_pc;
  logic [7:0]  jxx_before, mis_before, ret_before;

  initial begin
    vecs[0] = '{JXX,   64'h100, 64'h9,  64'h100};
    vecs[1] = '{CALL,  64'h200, 64'h15, 64'h200};
    vecs[2] = '{RET,   64'h777, 64'h31, 64'h31};
    vecs[3] = '{OPQ,   64'h555, 64'h2,  64'h2};
    vecs[4] = '{4'hF,  64'h123, 64'hA0, 64'hA0};
    vecs[5] = '{4'h0,  64'hDEADBEEF_00000000, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0};

    // Reset state and hold through an edge
    rst = 1; idle_inputs(); model_reset();
    #2;
    check_all("rst0");
    @(posedge clk); #1;
    check_all("rst_hold");
    rst = 0;

    // Load 0x40 via a JXX so a counter is nonzero, then reset mid-cycle
    f_icode = JXX; f_valC = 64'h40; f_valP = 64'h4;
    tick("pre", 1);
    chk("pre.pc40", pc8, 64'h40);
    idle_inputs();
    #3;
    rst = 1; model_reset();
    #1;
    chk("async_rst.pc", pc8, 64'h0);
    chk("async_rst.jxx", {56'h0, jxx8}, 64'h0);
    @(posedge clk); #1;
    check_all("rst_mid_hold");
    rst = 0;
    f_icode = NOP; f_valP = 64'h1;
    tick("release", 1);
    chk("release.pc1", pc32, 64'h1);

    // Table-driven prediction vectors
    for (int i = 0; i < 6; i++) begin
      f_icode = vecs[i].icode; f_valC = vecs[i].valc; f_valP = vecs[i].valp;
      tick($sformatf("vec%0d", i), 1);
      chk($sformatf("vec%0d.exp", i), pc8, vecs[i].exp_pc);
    end

    // Stalled JXX: held 3 cycles, counted once on release
    held_pc = pc8; jxx_before = jxx8;
    f_icode = JXX; f_valC = 64'h80; f_valP = 64'h8; F_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick($sformatf("stall%0d", i), 1);
      chk($sformatf("stall%0d.held", i), pc8, held_pc);
    end
    F_stall = 0;
    tick("unstall", 1);
    chk("unstall.pc80", pc8, 64'h80);
    chk("unstall.jxx+1", {56'h0, jxx8}, {56'h0, jxx_before + 8'd1});

    // Mispredict and RET counting from cleared state
    idle_inputs(); cnt_clr = 1;
    tick("clr", 1);
    cnt_clr = 0; M_icode = JXX; M_Cnd = 0;
    tick("mis0", 1);
    tick("mis1", 1);
    M_Cnd = 1;
    tick("mis_taken", 1);
    chk("mis.eq2", {56'h0, mis8}, 64'h2);
    M_icode = NOP; W_icode = RET; W_stall = 1;
    tick("ret_stall", 1);
    chk("ret_stall.eq0", {56'h0, ret8}, 64'h0);
    W_stall = 0;
    tick("ret_go", 1);
    chk("ret_go.eq1", {56'h0, ret8}, 64'h1);

    // Saturation of the 8-bit counter
    idle_inputs(); cnt_clr = 1;
    tick("clr2", 1);
    cnt_clr = 0; f_icode = JXX;
    for (int i = 0; i < 300; i++) begin
      f_valC = 64'h1000 + 64'(i);
      tick("sat", i >= 250);
    end
    chk("sat.jxx8", {56'h0, jxx8}, 64'hFF);
    chk("sat.jxx32", {32'h0, jxx32}, 64'd300);
    cnt_clr = 1; f_valC = 64'h2468;
    tick("clr_vs_inc", 1);
    chk("clr_vs_inc.jxx", {56'h0, jxx8}, 64'h0);
    chk("clr_vs_inc.pc", pc8, 64'h2468);

    // Simultaneous events
    idle_inputs(); cnt_clr = 1;
    tick("clr3", 1);
    cnt_clr = 0; M_icode = JXX; M_Cnd = 0;
    tick("pre_sim", 1);
    jxx_before = jxx8; mis_before = mis8; ret_before = ret8;
    f_icode = JXX; f_valC = 64'h300; W_icode = RET;
    tick("sim", 1);
    chk("sim.jxx", {56'h0, jxx8}, {56'h0, jxx_before + 8'd1});
    chk("sim.mis", {56'h0, mis8}, {56'h0, mis_before + 8'd1});
    chk("sim.ret", {56'h0, ret8}, {56'h0, ret_before + 8'd1});

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      f_icode = (r < 3) ? JXX : (r == 3) ? CALL : (r == 4) ? RET : 4'($urandom_range(0, 15));
      f_valC  = {$urandom, $urandom};
      f_valP  = {$urandom, $urandom};
      F_stall = ($urandom_range(0, 3) == 0);
      M_icode = ($urandom_range(0, 1) == 0) ? JXX : 4'($urandom_range(0, 15));
      M_Cnd   = 1'($urandom_range(0, 1));
      W_icode = ($urandom_range(0, 1) == 0) ? RET : 4'($urandom_range(0, 15));
      W_stall = ($urandom_range(0, 4) == 0);
      cnt_clr = ($urandom_range(0, 49) == 0);
      tick($sformatf("rnd%0d", i), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
